// File: rtl/issue_ctrl.sv
// RV32I R-type issue controller: scoreboard-based RAW stall, post-reset flush and halt/drain.
// Optional ISSUE_CTRL_STATS_EN adds issue and bubble counters.
module issue_ctrl #(
  parameter int unsigned PIPE_DEPTH = 3,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_instr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] instr,
  input  logic        halt_req,
  output logic        halted,
  output logic        illegal
`ifdef ISSUE_CTRL_STATS_EN
  ,
  output logic [31:0] issue_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  localparam logic [6:0]  OpcOp = 7'b0110011;
  localparam int unsigned CntW  = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  typedef enum logic [2:0] {StFlush, StRun, StStall, StDrain, StHalted} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [31:0]             instr_q, instr_d;
  logic                    halted_q, halted_d;
  logic                    illegal_q, illegal_d;
  logic [PIPE_DEPTH-1:0]   sb_v_q, sb_v_d;
  logic [4:0]              sb_rd_q [PIPE_DEPTH];
  logic [4:0]              sb_rd_d [PIPE_DEPTH];

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic       is_op, hazard, accept, push;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign is_op  = (opcode == OpcOp);

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
      if (sb_v_q[i] && (((rs1 != 5'd0) && (sb_rd_q[i] == rs1)) ||
                        ((rs2 != 5'd0) && (sb_rd_q[i] == rs2)))) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard && is_op;
  end

  always_comb begin
    in_ready = 1'b0;
    if ((state_q == StRun) || (state_q == StStall)) begin
      in_ready = !hazard && !halt_req;
    end
  end

  assign accept = in_valid && in_ready;
  assign push   = accept && is_op && (rd != 5'd0);

  // Scoreboard shifts every cycle; an entry ages out after PIPE_DEPTH cycles.
  always_comb begin
    sb_v_d[0]  = push;
    sb_rd_d[0] = push ? rd : 5'd0;
    for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
      sb_v_d[i]  = sb_v_q[i-1];
      sb_rd_d[i] = sb_rd_q[i-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    instr_d   = NOP_INSTR;
    illegal_d = 1'b0;
    if (accept) begin
      instr_d   = is_op ? in_instr : NOP_INSTR;
      illegal_d = !is_op;
    end
    unique case (state_q)
      StFlush: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(PIPE_DEPTH - 1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (halt_req) begin
          state_d = StDrain;
        end else if (in_valid && hazard) begin
          state_d = StStall;
        end
      end
      StStall: begin
        if (halt_req) begin
          state_d = StDrain;
        end else if (accept || !in_valid) begin
          state_d = StRun;
        end
      end
      StDrain: begin
        if (sb_v_q == '0) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        if (!halt_req) begin
          state_d = StRun;
        end
      end
      default: state_d = StFlush;
    endcase
    halted_d = (state_d == StHalted);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StFlush;
      cnt_q     <= '0;
      instr_q   <= NOP_INSTR;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      sb_v_q    <= '0;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        sb_rd_q[i] <= 5'd0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      sb_v_q    <= sb_v_d;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
        sb_rd_q[i] <= sb_rd_d[i];
      end
    end
  end

  assign instr   = instr_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

`ifdef ISSUE_CTRL_STATS_EN
  logic [31:0] issue_cnt_q, issue_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // No accepts and no STALL cycles occur while halted, so both counters hold there.
  always_comb begin
    issue_cnt_d  = issue_cnt_q + 32'(accept && is_op);
    bubble_cnt_d = bubble_cnt_q + 32'((state_q == StStall) && !in_ready);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      issue_cnt_q  <= issue_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign issue_cnt  = issue_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Randomized and directed bench for issue_ctrl against a timestamp-based reference model.
module tb_issue_ctrl;

  localparam int          D   = 3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_instr = 32'd0;
  logic        in_valid = 1'b0;
  logic        halt_req = 1'b0;
  logic        in_ready;
  logic [31:0] instr;
  logic        halted;
  logic        illegal;
`ifdef ISSUE_CTRL_STATS_EN
  logic [31:0] issue_cnt;
  logic [31:0] bubble_cnt;
`endif

  issue_ctrl #(.PIPE_DEPTH(D), .NOP_INSTR(NOP)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_instr (in_instr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr    (instr),
    .halt_req (halt_req),
    .halted   (halted),
    .illegal  (illegal)
`ifdef ISSUE_CTRL_STATS_EN
    ,
    .issue_cnt  (issue_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (check %0d)", tag, got, exp, n_checks);
  endtask

  // Reference model: a register is busy for D cycles after the cycle its producer was accepted.
  int          cyc = 0;
  int          last_wr [32];
  int          last_any;
  int          flush_left;
  int          mode;  // 0 issuing, 1 draining, 2 halted
  bit          stalled;
  bit          model_on = 1'b0;
  logic [31:0] exp_instr;
  bit          exp_halted, exp_illegal;
  int unsigned exp_issue, exp_bubble;
  bit          last_acc, last_ready;

  task automatic step(input bit rst, input bit v, input logic [31:0] ins, input bit h);
    bit op, haz, rdy, acc;
    int rd, rs1, rs2;
    @(negedge clock);
    if (model_on) begin
      check("instr", instr, exp_instr);
      check("halted", {31'd0, halted}, {31'd0, exp_halted});
      check("illegal", {31'd0, illegal}, {31'd0, exp_illegal});
`ifdef ISSUE_CTRL_STATS_EN
      check("issue_cnt", issue_cnt, exp_issue);
      check("bubble_cnt", bubble_cnt, exp_bubble);
`endif
    end
    reset = rst; in_valid = v; in_instr = ins; halt_req = h;
    #1;
    acc = 1'b0;
    rdy = 1'b0;
    exp_instr = NOP;
    exp_illegal = 1'b0;
    if (rst) begin
      for (int i = 0; i < 32; i++) last_wr[i] = -1000;
      last_any = -1000;
      flush_left = D;
      mode = 0;
      stalled = 1'b0;
      exp_halted = 1'b0;
      exp_issue = 0;
      exp_bubble = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      op  = (ins[6:0] == 7'b0110011);
      rd  = int'(ins[11:7]);
      rs1 = int'(ins[19:15]);
      rs2 = int'(ins[24:20]);
      haz = op && ((rs1 != 0 && cyc - last_wr[rs1] <= D) || (rs2 != 0 && cyc - last_wr[rs2] <= D));
      if (flush_left > 0) begin
        flush_left--;
      end else if (mode == 0) begin
        rdy = !haz && !h;
        acc = v && rdy;
        if (stalled && !rdy) exp_bubble++;
        if (acc) begin
          exp_instr = op ? ins : NOP;
          exp_illegal = !op;
          if (op) exp_issue++;
          if (op && rd != 0) begin
            last_wr[rd] = cyc;
            last_any = cyc;
          end
        end
        stalled = v && !acc && !h;
        if (h) mode = 1;
        exp_halted = 1'b0;
      end else if (mode == 1) begin
        stalled = 1'b0;
        if (cyc - last_any > D) begin
          mode = 2;
          exp_halted = 1'b1;
        end
      end else begin
        if (!h) mode = 0;
        exp_halted = h;
      end
      check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    end
    last_acc = acc;
    last_ready = rdy;
    cyc++;
  endtask

  // Presents ins until the model says it is taken; waits counts cycles including the accept.
  task automatic issue(input logic [31:0] ins, input bit h, output int waits);
    waits = 0;
    do begin
      step(1'b0, 1'b1, ins, h);
      waits++;
    end while (!last_acc && waits < 20);
    if (!last_acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc;
    logic [6:0] f7;
    opc = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'b0110011;
    f7  = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    return {f7, 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)), 3'($urandom),
            5'($urandom_range(0, 4)), opc};
  endfunction

  localparam logic [31:0] AddX3 = 32'h0020_81B3;
  localparam logic [31:0] XorX4 = 32'h0020_C233;
  localparam logic [31:0] SubX5 = 32'h4021_82B3;
  localparam logic [31:0] AddX0 = 32'h0020_8033;
  localparam logic [31:0] AddZz = 32'h0000_01B3;

  initial begin
    int w;
    bit v, h;
    logic [31:0] ins;

    step(1'b1, 1'b1, AddX3, 1'b0);
    step(1'b1, 1'b1, AddX3, 1'b0);
    issue(AddX3, 1'b0, w); check("flush_wait", w, 4);
    issue(XorX4, 1'b0, w); check("indep_wait", w, 1);
    idle(4);
    issue(AddX3, 1'b0, w);
    issue(SubX5, 1'b0, w); check("raw_d1_wait", w, D + 1);
    idle(4);
    issue(AddX3, 1'b0, w);
    idle(1);
    issue(SubX5, 1'b0, w); check("raw_d2_wait", w, D);
    idle(4);
    issue(AddX0, 1'b0, w); check("x0_dst_wait", w, 1);
    issue(AddZz, 1'b0, w); check("x0_src_wait", w, 1);
    issue(NOP, 1'b0, w);   check("nonop_wait", w, 1);
    idle(4);
    issue(AddX3, 1'b0, w);
    step(1'b0, 1'b1, SubX5, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, SubX5, 1'b1);
    check("halted_level", {31'd0, halted}, 32'd1);
    issue(SubX5, 1'b0, w); check("halt_release_wait", w, 2);
    idle(4);
    issue(AddX3, 1'b0, w);
    step(1'b0, 1'b1, SubX5, 1'b0);
    step(1'b1, 1'b1, SubX5, 1'b0);
    issue(SubX5, 1'b0, w); check("reset_flush_wait", w, D + 1);

    v = 1'b0; h = 1'b0; ins = 32'd0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) h = !h;
      if (!(v && !last_ready) || $urandom_range(0, 7) == 0) begin
        v = ($urandom_range(0, 3) != 0);
        ins = rand_instr();
      end
      if ($urandom_range(0, 399) == 0) step(1'b1, v, ins, h);
      else step(1'b0, v, ins, h);
    end
    idle(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Instruction issue controller between an instruction source (fetch or bench) and `mpu`.
- Accepts RV32I R-type instructions over a valid/ready handshake and drives the mpu's `instr` input every cycle.
- Tracks in-flight destination registers in a scoreboard and inserts NOP bubbles on read-after-write hazards, since `mpu` has no forwarding.
- Also handles post-reset pipeline flush and a halt/drain request.

Parameters:
- PIPE_DEPTH, 3: cycles from issue until the destination register write is visible to a following read; sets the scoreboard depth. Legal range 1..8.
- NOP_INSTR, 32'h00000013: bubble encoding (addi x0,x0,0).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_instr  in  32  candidate instruction
- in_valid  in  1  in_instr is valid
- in_ready  out  1  controller accepts in_instr this cycle; combinational
- instr  out  32  registered instruction to `mpu` `instr`
- halt_req  in  1  level request to stop accepting and drain
- halted  out  1  registered; pipeline empty and halted
- illegal  out  1  registered one-cycle pulse: accepted instruction had a non-OP opcode

Behaviour:
- Reset (synchronous, active-high):
  - instr=NOP_INSTR, halted=0, illegal=0.
  - Scoreboard cleared.
  - State=FLUSH, flush counter=0.
  - Reset asserted in any state aborts that state immediately; in-flight scoreboard entries are discarded.
- Decode fields: opcode=[6:0], rd=[11:7], rs1=[19:15], rs2=[24:20]. OP opcode=7'b0110011.
- Scoreboard: PIPE_DEPTH entries {v, rd[4:0]}, shifting every cycle.
  - sb[0] <= {1, rd} when an OP instruction with rd!=0 is accepted; otherwise {0, 0}.
  - sb[i] <= sb[i-1]; the oldest entry retires.
- Hazard (combinational): opcode==OP and any valid entry with rd equal to a nonzero rs1 or a nonzero rs2. x0 never causes a hazard.
- FSM states:
  - FLUSH: issue NOP, in_ready=0, counter increments. Go to RUN after PIPE_DEPTH cycles.
  - RUN:
    - in_ready = !hazard && !halt_req.
    - Accept (in_valid && in_ready): instr <= in_instr at the next edge, so latency is 1 cycle.
    - No accept: instr <= NOP_INSTR.
    - in_valid && hazard goes to STALL.
    - halt_req goes to DRAIN.
  - STALL:
    - Issue NOP. in_ready = !hazard; acceptance is allowed in the cycle the hazard clears.
    - Go to RUN on accept, or on in_valid dropping.
    - halt_req has priority and goes to DRAIN.
  - DRAIN: issue NOP, in_ready=0. Go to HALTED when all scoreboard entries are invalid.
  - HALTED:
    - halted=1, issue NOP, in_ready=0.
    - halt_req deassert goes to RUN with halted=0 at the same edge.
- in_ready may depend combinationally on in_valid/in_instr. The source must hold in_instr stable while in_valid && !in_ready.
- Non-OP opcode:
  - Accepted when in_ready (no hazard check).
  - Issued as NOP_INSTR, not written to the scoreboard.
  - illegal=1 for exactly one cycle, aligned with that NOP on instr.
- RAW distance: a dependent instruction directly after its producer sees PIPE_DEPTH stall cycles. At distance k (1..PIPE_DEPTH) it sees PIPE_DEPTH-k+1 stall cycles.
- halt_req asserted in the same cycle as in_valid blocks that acceptance.

Optional Feature:
- Macro ISSUE_CTRL_STATS_EN.
- When defined, add output ports:
  - issue_cnt, 32 bits: accepted OP instructions.
  - bubble_cnt, 32 bits: cycles in STALL with in_ready=0.
- Both counters reset to 0, wrap modulo 2^32, and hold while HALTED.
- When undefined, neither port nor its logic exists, and the block's behaviour is otherwise identical.

Test Plan:
- Reset release with in_valid=1 held: in_ready=0 for exactly 3 cycles and instr=32'h00000013; first accept on cycle 4.
- add x3,x1,x2 (32'h002081B3) then xor x4,x1,x2 (32'h0020C233) back-to-back: both accepted on consecutive cycles, no bubble; instr shows each one cycle after acceptance.
- add x3,x1,x2 then sub x5,x3,x2 (32'h402182B3): exactly 3 NOP cycles between them on instr; sub accepted on the 4th cycle after add.
- add x0,x1,x2 (32'h00208033) then add x3,x0,x0 (32'h000001B3): no stall. Then 32'h00000013 (addi) accepted: illegal pulses 1 cycle, instr=NOP.
- Stall on x3, then halt_req=1 mid-STALL: sub not accepted; halted=1 once scoreboard empties (≤3 cycles). Release halt_req: RUN, sub accepted next cycle with no stall.
- Reset asserted mid-STALL: next cycle instr=NOP, scoreboard empty, 3 FLUSH cycles. With ISSUE_CTRL_STATS_EN defined, issue_cnt=0 and bubble_cnt=0.
